// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer. Each entry holds a saturating direction
// counter. The fetch-stage lookup is combinational, so the predicted next PC
// is available in the same cycle. The branch-resolve stage trains the table
// through a write port that takes one cycle.
//
// Each entry has its own valid bit, so every target value is legal. No
// target encoding is reserved to mean "uninitialised".
//
// Optional feature: define BP_GSHARE_EN to XOR a global history register into
// both the lookup index and the update index.
//
// Ports:
//   i_clk            clock; all state updates happen on its rising edge
//   i_reset_n        asynchronous active-low reset
//   i_pc             fetch-stage lookup PC
//   o_next_pc        predicted next fetch PC
//   o_predict_taken  1 when o_next_pc comes from the BTB target
//   i_upd_valid      resolve-stage update strobe
//   i_upd_is_branch  resolved instruction is a conditional branch
//   i_upd_pc         PC of the resolved branch
//   i_upd_taken      actual branch outcome
//   i_upd_target     branch target, valid even when the branch is not taken
// ---------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int WORD_SIZE    = 16,
  parameter int INDEX_BITS   = 8,
  parameter int COUNTER_BITS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [WORD_SIZE-1:0] i_pc,
  output logic [WORD_SIZE-1:0] o_next_pc,
  output logic                 o_predict_taken,
  input  logic                 i_upd_valid,
  input  logic                 i_upd_is_branch,
  input  logic [WORD_SIZE-1:0] i_upd_pc,
  input  logic                 i_upd_taken,
  input  logic [WORD_SIZE-1:0] i_upd_target
);

  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] CTR_MAX = {COUNTER_BITS{1'b1}};
  localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(1) << (COUNTER_BITS - 1);

  logic                    r_valid  [ENTRIES];
  logic [COUNTER_BITS-1:0] r_ctr    [ENTRIES];
  logic [TAG_BITS-1:0]     r_tag    [ENTRIES];
  logic [WORD_SIZE-1:0]    r_target [ENTRIES];

  logic [INDEX_BITS-1:0]   w_idx;
  logic [INDEX_BITS-1:0]   w_uidx;
  logic [TAG_BITS-1:0]     w_tag;
  logic [TAG_BITS-1:0]     w_utag;
  logic                    w_hit;
  logic                    w_uhit;
  logic                    w_upd_en;
  logic                    w_entry_we;
  logic                    w_meta_we;
  logic [COUNTER_BITS-1:0] w_ctr_cur;
  logic [COUNTER_BITS-1:0] w_ctr_new;

  assign w_upd_en = i_upd_valid && i_upd_is_branch;
  assign w_tag    = i_pc[WORD_SIZE-1:INDEX_BITS];
  assign w_utag   = i_upd_pc[WORD_SIZE-1:INDEX_BITS];

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] r_ghr;

  // Both indices use the history from before this update, so a lookup and
  // an update in the same cycle hash with the same ghr value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ghr <= '0;
    end else if (w_upd_en) begin
      r_ghr <= {r_ghr[INDEX_BITS-2:0], i_upd_taken};
    end
  end

  assign w_idx  = i_pc[INDEX_BITS-1:0] ^ r_ghr;
  assign w_uidx = i_upd_pc[INDEX_BITS-1:0] ^ r_ghr;
`else
  assign w_idx  = i_pc[INDEX_BITS-1:0];
  assign w_uidx = i_upd_pc[INDEX_BITS-1:0];
`endif

  // Lookup reads the registered contents, so an update to the same entry in
  // this cycle becomes visible only in the next cycle.
  assign w_hit           = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign o_predict_taken = w_hit && r_ctr[w_idx][COUNTER_BITS-1];
  assign o_next_pc       = o_predict_taken ? r_target[w_idx] : (i_pc + WORD_SIZE'(1));

  assign w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_ctr_cur = r_ctr[w_uidx];

  // A not-taken miss never allocates. Every taken update rewrites the
  // tag/target pair. On a hit the tag it writes is identical to the stored one.
  assign w_entry_we = w_upd_en && (w_uhit || i_upd_taken);
  assign w_meta_we  = w_upd_en && i_upd_taken;

  always_comb begin
    w_ctr_new = w_ctr_cur;
    if (!w_uhit) begin
      w_ctr_new = CTR_WT;
    end else if (i_upd_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_new = w_ctr_cur + COUNTER_BITS'(1);
    end else begin
      if (w_ctr_cur != '0) w_ctr_new = w_ctr_cur - COUNTER_BITS'(1);
    end
  end

  // Valid bits and counters are cleared asynchronously. The tag and target
  // arrays need no reset because a cleared valid bit masks them.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= '0;
      end
    end else if (w_entry_we) begin
      r_valid[w_uidx] <= 1'b1;
      r_ctr[w_uidx]   <= w_ctr_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_meta_we) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= i_upd_target;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

  localparam int WS  = 16;
  localparam int IB  = 8;
  localparam int CB  = 2;
  localparam int NE  = 256;
  localparam int CMX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WS-1:0] pc = '0;
  logic [WS-1:0] next_pc;
  logic          predict_taken;
  logic          upd_valid = 1'b0;
  logic          upd_is_branch = 1'b0;
  logic [WS-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic [WS-1:0] upd_target = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain integer tables and history.
  int m_valid  [NE];
  int m_tag    [NE];
  int m_target [NE];
  int m_ctr    [NE];
  int m_ghr;

  branch_target_predictor #(.WORD_SIZE(WS), .INDEX_BITS(IB), .COUNTER_BITS(CB)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_pc            (pc),
    .o_next_pc       (next_pc),
    .o_predict_taken (predict_taken),
    .i_upd_valid     (upd_valid),
    .i_upd_is_branch (upd_is_branch),
    .i_upd_pc        (upd_pc),
    .i_upd_taken     (upd_taken),
    .i_upd_target    (upd_target)
  );

  always #5 clk = ~clk;

  function automatic int model_index(input int addr);
`ifdef BP_GSHARE_EN
    return (addr % NE) ^ m_ghr;
`else
    return addr % NE;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_ghr = 0;
  endtask

  task automatic model_update(input int addr, input int taken, input int tgt);
    int idx;
    int hit;
    idx = model_index(addr);
    hit = (m_valid[idx] != 0) && (m_tag[idx] == addr / NE);
    if (hit) begin
      if (taken != 0) begin
        m_ctr[idx]    = (m_ctr[idx] + 1 > CMX) ? CMX : m_ctr[idx] + 1;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (taken != 0) begin
      m_valid[idx]  = 1;
      m_tag[idx]    = addr / NE;
      m_target[idx] = tgt;
      m_ctr[idx]    = 2;
    end
`ifdef BP_GSHARE_EN
    m_ghr = (m_ghr * 2 + taken) % NE;
`endif
  endtask

  task automatic check_pred(input string name);
    int idx;
    int hit;
    logic          exp_taken;
    logic [WS-1:0] exp_next;
    idx       = model_index(int'(pc));
    hit       = (m_valid[idx] != 0) && (m_tag[idx] == int'(pc) / NE);
    exp_taken = (hit != 0) && (m_ctr[idx] >= 2);
    exp_next  = exp_taken ? WS'(m_target[idx]) : WS'((int'(pc) + 1) % 65536);
    n_cmp++;
    assert (predict_taken === exp_taken) else begin
      n_fail++;
      $error("FAIL %s.taken pc=%h got=%b exp=%b", name, pc, predict_taken, exp_taken);
    end
    n_cmp++;
    assert (next_pc === exp_next) else begin
      n_fail++;
      $error("FAIL %s.next_pc pc=%h got=%h exp=%h", name, pc, next_pc, exp_next);
    end
    $display("%s: pc=%h upd=%b/%b upc=%h t=%b tgt=%h -> taken=%b next=%h", name, pc,
             upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target, predict_taken, next_pc);
  endtask

  // One cycle: drive inputs, check the pre-update prediction, then clock.
  task automatic step(input logic [WS-1:0] l_pc, input logic uv, input logic ub,
                      input logic [WS-1:0] upc, input logic ut,
                      input logic [WS-1:0] utgt, input string name);
    @(negedge clk);
    pc = l_pc; upd_valid = uv; upd_is_branch = ub;
    upd_pc = upc; upd_taken = ut; upd_target = utgt;
    #1;
    check_pred(name);
    @(posedge clk);
    if (uv && ub) model_update(int'(upc), int'(ut), int'(utgt));
  endtask

  task automatic look(input logic [WS-1:0] l_pc, input string name);
    step(l_pc, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, name);
  endtask

  // Reset asserted while a taken update is pending: the update must be lost.
  task automatic pulse_reset(input logic [WS-1:0] l_pc, input string name);
    @(negedge clk);
    pc = l_pc; upd_valid = 1'b1; upd_is_branch = 1'b1;
    upd_pc = l_pc; upd_taken = 1'b1; upd_target = 16'h1234;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_pred({name, ".async"});
    @(posedge clk);
    #1;
    check_pred({name, ".held"});
    @(negedge clk);
    rst_n = 1'b1; upd_valid = 1'b0;
  endtask

  function automatic logic [WS-1:0] pick_pc();
    case ($urandom_range(0, 6))
      0: return 16'h0040;
      1: return 16'h0140;
      2: return 16'h0041;
      3: return 16'h0010;
      4: return 16'hFFFF;
      5: return 16'h0240;
      default: return WS'($urandom);
    endcase
  endfunction

  initial begin
    model_clear();
    for (int i = 0; i < NE; i++) begin
      m_tag[i]    = 0;
      m_target[i] = 0;
    end
    pc = 16'h0040;
    #2;
    check_pred("reset_low");
    @(negedge clk);
    rst_n = 1'b1;

    look(16'h0040, "after_reset");
    step(16'h0040, 1, 1, 16'h0040, 1, 16'h0050, "alloc_same_cycle");
    look(16'h0040, "alloc_hit");
    step(16'h0040, 1, 1, 16'h0040, 0, 16'h0050, "nt1");
    look(16'h0040, "ctr01");
    step(16'h0040, 1, 1, 16'h0040, 0, 16'h0050, "nt2");
    step(16'h0040, 1, 1, 16'h0040, 0, 16'h0050, "nt3_sat");
    step(16'h0040, 1, 1, 16'h0040, 1, 16'h0060, "t_from0");
    look(16'h0040, "ctr01_again");
    step(16'h0040, 1, 1, 16'h0040, 1, 16'h0070, "t_to10");
    look(16'h0040, "ctr10_newtgt");
    step(16'h0040, 1, 1, 16'h0040, 1, 16'h0070, "t_to11");
    step(16'h0040, 1, 1, 16'h0040, 1, 16'h0070, "t_sat11");
    step(16'h0040, 1, 1, 16'h0040, 0, 16'h0070, "nt_from11");
    look(16'h0040, "ctr10_hold");
    look(16'h0140, "tag_mismatch");
    step(16'h0140, 1, 1, 16'h0140, 0, 16'h0300, "nt_miss_noalloc");
    look(16'h0140, "still_miss");
    step(16'h0140, 1, 1, 16'h0140, 1, 16'h0200, "replace");
    look(16'h0140, "replaced_hit");
    look(16'h0040, "evicted");
    step(16'h0140, 1, 0, 16'h0140, 0, 16'h0000, "not_branch");
    look(16'h0140, "not_branch_hold");
    step(16'h0140, 0, 1, 16'h0140, 0, 16'h0000, "not_valid");
    look(16'h0140, "not_valid_hold");
    look(16'hFFFF, "wrap");
    step(16'h0010, 1, 1, 16'h0010, 1, 16'h0A00, "gs_t1");
    step(16'h0010, 1, 1, 16'h0010, 1, 16'h0B00, "gs_t2");
    look(16'h0010, "gs_look");
    look(16'h0011, "gs_look11");
    pulse_reset(16'h0140, "rst_mid");
    look(16'h0140, "post_reset");
    look(16'h0010, "post_reset2");

    for (int i = 0; i < 600; i++) begin
      logic [WS-1:0] rp;
      logic [WS-1:0] rup;
      rp  = pick_pc();
      rup = ($urandom_range(0, 3) == 0) ? rp : pick_pc();
      step(rp, $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, rup,
           $urandom_range(0, 2) != 0, WS'($urandom), "rand");
      if (i % 150 == 149) pulse_reset(pick_pc(), "rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
